// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multi-cycle RISC-V control path: opcodes,
// sequencer state encodings and ALU operation selects.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

endpackage

// File: rtl/opcode_decode.sv
// Combinational classifier for the four opcodes the sequencer supports.
module opcode_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       is_r,
  output logic       is_ld,
  output logic       is_sd,
  output logic       is_beq,
  output logic       legal
);

  assign is_r   = (opcode == OP_R);
  assign is_ld  = (opcode == OP_LD);
  assign is_sd  = (opcode == OP_SD);
  assign is_beq = (opcode == OP_BEQ);
  assign legal  = is_r | is_ld | is_sd | is_beq;

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// drives datapath enables/selects, counts retired instructions, traps on bad opcodes.
module multi_cycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E,
  input  logic [6:0]       opcode,
  input  logic             zero,
  output logic             ir_we,
  output logic             ab_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [2:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  state_t           state_reg;
  logic [6:0]       op_reg;
  logic [CNT_W-1:0] retired_reg;

  logic [6:0] dec_op;
  logic       is_r, is_ld, is_sd, is_beq, legal;

  logic ir_we_c, ab_we_c, pc_we_c, mem_read_c, mem_write_c, reg_write_c;
  logic retire_c, retire_now;

  // In DECODE the live opcode decides legality; afterwards only the latch matters.
  assign dec_op = (state_reg == S_DECODE) ? opcode : op_reg;

  opcode_decode u_dec (
    .opcode (dec_op),
    .is_r   (is_r),
    .is_ld  (is_ld),
    .is_sd  (is_sd),
    .is_beq (is_beq),
    .legal  (legal)
  );

  always_comb begin
    ir_we_c     = 1'b0;
    ab_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    retire_c    = 1'b0;
    pc_src      = 1'b0;
    alu_src     = 1'b0;
    alu_op      = ALU_OP_ADD;
    mem_to_reg  = 1'b0;
    trap        = 1'b0;
    if (!reset) begin
      case (state_reg)
        S_FETCH:  ir_we_c = 1'b1;
        S_DECODE: ab_we_c = 1'b1;
        S_EXEC: begin
          if (is_r) begin
            alu_op = ALU_OP_FUNCT;
          end else if (is_ld || is_sd) begin
            alu_src = 1'b1;
            alu_op  = ALU_OP_ADD;
          end else if (is_beq) begin
            alu_op   = ALU_OP_SUB;
            pc_we_c  = 1'b1;
            pc_src   = zero;
            retire_c = 1'b1;
          end
        end
        S_MEM: begin
          alu_src = 1'b1;
          alu_op  = ALU_OP_ADD;
          if (is_ld) mem_read_c = 1'b1;
          if (is_sd) begin
            mem_write_c = 1'b1;
            pc_we_c     = 1'b1;
            retire_c    = 1'b1;
          end
        end
        S_WB: begin
          reg_write_c = 1'b1;
          pc_we_c     = 1'b1;
          retire_c    = 1'b1;
          if (is_r) alu_op = ALU_OP_FUNCT;
          if (is_ld) begin
            mem_read_c = 1'b1;
            mem_to_reg = 1'b1;
          end
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

  // E only gates the write enables; selects stay state-based while frozen.
  assign ir_we      = ir_we_c & E;
  assign ab_we      = ab_we_c & E;
  assign pc_we      = pc_we_c & E;
  assign mem_read   = mem_read_c & E;
  assign mem_write  = mem_write_c & E;
  assign reg_write  = reg_write_c & E;
  assign retire_now = retire_c & E;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      op_reg      <= '0;
      retired_reg <= '0;
    end else if (E) begin
      if (retire_now) retired_reg <= retired_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      case (state_reg)
        S_FETCH: state_reg <= S_DECODE;
        S_DECODE: begin
          op_reg    <= opcode;
          state_reg <= legal ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          if (is_r)                state_reg <= S_WB;
          else if (is_ld || is_sd) state_reg <= S_MEM;
          else                     state_reg <= S_FETCH;
        end
        S_MEM:   state_reg <= is_ld ? S_WB : S_FETCH;
        S_WB:    state_reg <= S_FETCH;
        S_TRAP:  state_reg <= S_TRAP;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  assign state   = state_reg;
  assign retired = retired_reg;

endmodule
